// File: rtl/arb_pkg.sv
// Shared constants and types for the round-robin handshake arbiter.
package arb_pkg;

    localparam int ARB_NUM_REQ = 4;
    localparam int ARB_DATA_W  = 8;
    localparam int XFER_CNT_W  = 3;

    // Output-stage occupancy; the FULL encoding doubles as out_valid.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: scans req_valid starting one past
// last_grant, wrapping, and reports the first asserted requester.
module rr_picker
    import arb_pkg::*;
#(
    parameter  int NUM_REQ = ARB_NUM_REQ,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] winner_oh,
    output logic [ID_W-1:0]    winner_idx,
    output logic               any_valid
);

    // First valid index after last_grant wins; the found flag keeps later hits out.
    always_comb begin
        int idx;
        idx        = 0;
        winner_oh  = '0;
        winner_idx = '0;
        any_valid  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!any_valid && req_valid[idx]) begin
                any_valid      = 1'b1;
                winner_idx     = ID_W'(idx);
                winner_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_handshake_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output stage
// between NUM_REQ requesters.
// Optional build macro: ARB_XFER_COUNT_EN adds a 3-bit downstream
// transfer counter on port xfer_count.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_EMPTY | output register holds nothing; any winner is accepted
// ST_FULL  | out_data/out_id valid; new item only if drained this cycle
module rr_handshake_arbiter
    import arb_pkg::*;
#(
    parameter  int NUM_REQ = ARB_NUM_REQ,
    parameter  int DATA_W  = ARB_DATA_W,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_id,
    input  logic                      out_ready
`ifdef ARB_XFER_COUNT_EN
    ,
    output logic [XFER_CNT_W-1:0]     xfer_count
`endif
);

    out_state_t          state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     last_q, last_d;

    logic [NUM_REQ-1:0]  winner_oh;
    logic [ID_W-1:0]     winner_idx;
    logic                any_valid;
    logic                load_en;
    logic                up_xfer;
    logic                dn_xfer;
    logic [DATA_W-1:0]   sel_data;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_valid  (req_valid),
        .last_grant (last_q),
        .winner_oh  (winner_oh),
        .winner_idx (winner_idx),
        .any_valid  (any_valid)
    );

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_id    = id_q;

    // Stage can take an item when empty or being drained this cycle.
    // Ready is held low during reset so nothing looks accepted on a
    // cycle whose edge discards it.
    assign load_en   = (state_q == ST_EMPTY) || out_ready;
    assign up_xfer   = any_valid && load_en && !rst;
    assign dn_xfer   = out_valid && out_ready;
    assign req_ready = up_xfer ? winner_oh : '0;

    // Payload mux driven by the one-hot winner.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner_oh[i]) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state for the output stage and round-robin pointer.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        last_d  = last_q;
        if (up_xfer) begin
            state_d = ST_FULL;
            data_d  = sel_data;
            id_d    = winner_idx;
            last_d  = winner_idx;
        end else if (dn_xfer) begin
            state_d = ST_EMPTY;
        end
    end

    // Output stage and priority pointer registers.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

`ifdef ARB_XFER_COUNT_EN
    logic [XFER_CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d      = dn_xfer ? cnt_q + XFER_CNT_W'(1) : cnt_q;
    assign xfer_count = cnt_q;

    // Free-running downstream transfer counter, wraps naturally.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule
